// File: rtl/mem_responder.sv
// Single-port word memory responder: captures one request, inserts WAIT_CYCLES wait states, then acks.
// Optional completed-access counter enabled by defining MEM_RESPONDER_STATS_EN.
module mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [11:0] wdata,
    output logic [11:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [15:0] acc_count
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_q, busy_q;
    logic [11:0] rdata_q;

    logic        we_q;
    logic [11:0] addr_q, wdata_q;
    logic [11:0] mem_q [DEPTH];

    logic        capture, enter_resp;
    logic        acc_we;
    logic [11:0] acc_addr, acc_wdata;
    logic [AW-1:0] acc_idx;

    // With zero wait states the access happens on the capture edge, so it uses the live inputs.
    always_comb begin
        capture    = req && (state_q != WAIT);
        enter_resp = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_we     = we_q;
        acc_addr   = addr_q;
        acc_wdata  = wdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (req) begin
                    cnt_d = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                        acc_we     = we;
                        acc_addr   = addr;
                        acc_wdata  = wdata;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_idx = acc_addr[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 12'h000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= enter_resp;
            busy_q  <= (state_d != IDLE);
            if (enter_resp && !acc_we) begin
                rdata_q <= mem_q[acc_idx];
            end
        end
    end

    // NOTE: storage and captured request fields carry no reset; keeping them out of the reset block
    // stops rst from becoming a data enable, and rst only gates the write so storage persists.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
        end
        if (!rst && enter_resp && acc_we) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 16'h0000;
        end else if (enter_resp) begin
            acc_q <= acc_q + 16'd1;
        end
    end

    assign acc_count = acc_q;
`else
    assign acc_count = 16'h0000;
`endif

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of wait-state cycles inserted between request capture and response; legal range 0..15.
REQ-002 Parameter DEPTH, default 4096: number of 12-bit words stored; address bits above log2(DEPTH) are ignored.
REQ-003 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous to clk and active-high.
REQ-005 Port: req  input  1  request strobe from the datapath memory port.
REQ-006 Port: we  input  1  write-enable qualifier of the request; 1 means write, 0 means read.
REQ-007 Port: addr  input  12  word address of the request.
REQ-008 Port: wdata  input  12  write data of the request.
REQ-009 Port: rdata  output  12  read data; valid while ack=1 for a read.
REQ-010 Port: ack  output  1  one-cycle completion pulse for the captured request.
REQ-011 Port: busy  output  1  high whenever a request is pending (state not IDLE).
REQ-012 Port: acc_count  output  16  completed-access counter (see Configuration).

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP; busy = (state != IDLE).
REQ-014 In IDLE with req=1, the rising edge SHALL capture addr, we and wdata into internal registers and load the wait counter with WAIT_CYCLES.
- Next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 In WAIT, the counter SHALL decrement each cycle; on the edge where it reaches 0 the FSM enters RESP.
- Capture-to-ack latency is exactly WAIT_CYCLES+1 cycles.
REQ-016 req, we, addr and wdata SHALL be ignored while in WAIT; the captured values alone define the access.
REQ-017 On the edge entering RESP:
- A captured write SHALL be committed to storage.
- A captured read SHALL load rdata from storage.
REQ-018 ack SHALL be 1 exactly while state = RESP, i.e. for one cycle per request.
REQ-019 rdata SHALL hold its last loaded value until the next read completes; writes do not change rdata.
REQ-020 In RESP with req=1, a new request SHALL be captured on that edge under the same rules as REQ-014 (back-to-back, no IDLE bubble); otherwise the next state is IDLE.
REQ-021 A read captured back-to-back after a write to the same address SHALL return the newly written data.
REQ-022 Storage contents SHALL not be initialised by rst and SHALL persist across resets.

Reset
REQ-023 rst=1 at an edge SHALL force state=IDLE, ack=0, busy=0, rdata=12'h000 and wait counter=0, taking priority over every other event.
REQ-024 A request captured but not yet in RESP when rst is asserted SHALL be discarded; no storage write occurs.
REQ-025 req sampled on an edge with rst=1 SHALL NOT be captured.

Configuration
REQ-026 With macro MEM_RESPONDER_STATS_EN defined, acc_count SHALL reset to 0 and increment by 1 on every edge entering RESP, wrapping 16'hFFFF to 16'h0000.
REQ-027 With MEM_RESPONDER_STATS_EN undefined, acc_count SHALL be tied to 16'h0000 and no counter logic SHALL be present.

Verification
REQ-028 WAIT_CYCLES=2: write 12'hA5C to addr 12'h010, then read 12'h010 -> ack rises 3 cycles after each capture, rdata=12'hA5C during the read ack.
REQ-029 WAIT_CYCLES=0: req held high across four reads of addrs 0..3 preloaded 1..4 -> ack high on four consecutive cycles, rdata sequence 1,2,3,4, busy never drops.
REQ-030 Back-to-back write 12'h7FF then read at 12'h123 with req high in RESP -> read ack returns 12'h7FF, with no IDLE cycle between the two accesses.
REQ-031 Write 12'h111 to addr 12'h020 captured, rst asserted for one cycle during WAIT, then read 12'h020 (previously 12'h000) -> no ack for the aborted write, busy=0 after reset, read returns 12'h000.
REQ-032 Change addr and wdata every cycle during WAIT of a read of 12'h005 holding 12'h0C3 -> rdata=12'h0C3 and storage is unmodified.
REQ-033 MEM_RESPONDER_STATS_EN defined, counter forced near wrap via 65537 accesses -> acc_count reads 16'h0001; with the macro undefined, acc_count stays 16'h0000 throughout.
